// File: rtl/esc_pkg.sv
// Shared constants and FSM state type for the ESC PWM link
// (default pulse offset/scale are also used by the ESC interface).
package esc_pkg;

    localparam int SPEED_W    = 11;
    localparam int TO_W       = 20;
    localparam int ESC_OFFSET = 6250;
    localparam int ESC_SCALE  = 3;
    localparam int ESC_TO_CYC = 1048575;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } esc_state_e;

endpackage

// File: rtl/esc_glitch_filter.sv
// Three-sample level qualifier: the output follows the input only after the
// input has held a new level for 3 consecutive samples (2 cycles of added delay).
module esc_glitch_filter (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Start out agreeing with the live level so a pulse in progress is never seen as a new rise.
            hist <= {2{din}};
            dout <= din;
        end else begin
            hist <= {hist[0], din};
            if (hist == 2'b11 && din) begin
                dout <= 1'b1;
            end else if (hist == 2'b00 && !din) begin
                dout <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/esc_pwm_decoder.sv
// ESC PWM pulse-width decoder: SPEED = floor((W - OFFSET) / SCALE) without a divider.
// Define ESC_DEC_GLITCH_FILT_EN to qualify the input with esc_glitch_filter.
module esc_pwm_decoder
    import esc_pkg::*;
#(
    parameter int OFFSET = ESC_OFFSET,
    parameter int SCALE  = ESC_SCALE,
    parameter int TO_CYC = ESC_TO_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PWM,
    output logic [SPEED_W-1:0] SPEED,
    output logic               vld,
    output logic               err,
    output logic               lost,
    output esc_state_e         fsm_state
);

    localparam int OFF_W = $clog2(OFFSET + 1);
    localparam int PRE_W = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [OFF_W-1:0]   OFF_MAX  = OFF_W'(OFFSET);
    localparam logic [OFF_W-1:0]   OFF_ONE  = OFF_W'(1);
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(SCALE - 1);
    localparam logic [PRE_W-1:0]   PRE_ONE  = PRE_W'(1);
    localparam logic [SPEED_W-1:0] ACC_MAX  = {SPEED_W{1'b1}};
    localparam logic [SPEED_W-1:0] ACC_ONE  = SPEED_W'(1);
    localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TO_CYC - 1);
    localparam logic [TO_W-1:0]    TO_ONE   = TO_W'(1);

    logic               pwm_s;
    logic [OFF_W-1:0]   off_cnt;
    logic [PRE_W-1:0]   pre_cnt;
    logic [SPEED_W-1:0] acc;
    logic               ovf;
    logic [TO_W-1:0]    to_cnt;
    logic               timeout;
    logic               short_pulse;

`ifdef ESC_DEC_GLITCH_FILT_EN
    esc_glitch_filter u_glitch_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (PWM),
        .dout (pwm_s)
    );
`else
    // Sampled even during reset so IDLE sees the true level on the first cycle out of reset.
    always_ff @(posedge clk) begin
        pwm_s <= PWM;
    end
`endif

    assign timeout     = (to_cnt == TO_LAST);
    assign short_pulse = (off_cnt != OFF_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state <= IDLE;
            off_cnt   <= '0;
            pre_cnt   <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            to_cnt    <= '0;
            SPEED     <= '0;
            vld       <= 1'b0;
            err       <= 1'b0;
            lost      <= 1'b1;
        end else begin
            vld <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    to_cnt <= '0;
                    if (!pwm_s) begin
                        fsm_state <= LOW;
                    end
                end

                LOW: begin
                    if (pwm_s) begin
                        // The entry cycle is itself the first high cycle of the pulse.
                        fsm_state <= HIGH;
                        to_cnt    <= '0;
                        off_cnt   <= OFF_ONE;
                        pre_cnt   <= '0;
                        acc       <= '0;
                        ovf       <= 1'b0;
                    end else if (timeout) begin
                        fsm_state <= IDLE;
                        lost      <= 1'b1;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end

                HIGH: begin
                    if (timeout) begin
                        // Stuck high: drop the pulse without publishing.
                        fsm_state <= IDLE;
                        lost      <= 1'b1;
                        to_cnt    <= '0;
                    end else if (!pwm_s) begin
                        fsm_state <= LOW;
                        to_cnt    <= to_cnt + TO_ONE;
                        SPEED     <= short_pulse ? '0 : acc;
                        err       <= short_pulse | ovf;
                        vld       <= 1'b1;
                        lost      <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                        if (off_cnt != OFF_MAX) begin
                            off_cnt <= off_cnt + OFF_ONE;
                        end else if (pre_cnt == PRE_LAST) begin
                            pre_cnt <= '0;
                            if (acc == ACC_MAX) begin
                                ovf <= 1'b1;
                            end else begin
                                acc <= acc + ACC_ONE;
                            end
                        end else begin
                            pre_cnt <= pre_cnt + PRE_ONE;
                        end
                    end
                end

                default: begin
                    fsm_state <= IDLE;
                    to_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/esc_pwm_decoder.md
# esc_pwm_decoder

Measures the high time of ESC-style PWM pulses and recovers the 11-bit speed command that produced them. It is the receiving end of the ESC PWM link, where pulse width = OFFSET + SCALE·SPEED clocks. It is used as a loopback checker behind the ESC interface and as the input stage of a bench-side motor model. It flags out-of-range widths and loss of signal.

## Interface
- OFFSET, 6250: clocks of high time that decode to SPEED 0
- SCALE, 3: clocks of high time per SPEED LSB
- TO_CYC, 1048575: clocks without a rising edge before signal is declared lost
- clk  in  1  system clock
- rst  in  1  reset; **synchronous and active-high**
- PWM  in  1  pulse input, synchronous to clk
- SPEED  out  11  last decoded speed
- vld  out  1  one-cycle strobe when SPEED/err update
- err  out  1  last pulse out of range
- lost  out  1  no rising edge for TO_CYC clocks, or no valid pulse since reset

## Operation
- PWM is registered once to give pwm_s (or filtered, see Configuration). The FSM runs on pwm_s.
- **States**
  - IDLE: reset state; waits for pwm_s=0, then goes to LOW. A pulse in progress at reset is discarded.
  - LOW: on pwm_s=1, goes to HIGH and clears the measurement counters.
  - HIGH: counts high cycles; on pwm_s=0, goes to LOW and publishes the result.
- **Measurement**
  - The offset counter counts each HIGH cycle, including the first, up to OFFSET.
  - After the offset counter reaches OFFSET, a mod-SCALE prescaler runs. Each wrap increments the 11-bit accumulator.
  - Result = floor((W−OFFSET)/SCALE), where W = high-cycle count. No divider is used.
- **Boundary conditions**
  - W < OFFSET: SPEED=0, err=1.
  - Accumulator would pass 2047: it saturates at 2047, an overflow flag is set, and on publish SPEED=2047, err=1. W=OFFSET+3·2047 is in range (err=0).
  - Any publish clears lost.
- **Timeout**
  - A 20-bit counter is cleared on each rising edge of pwm_s and runs in every other non-IDLE cycle.
  - At TO_CYC: lost=1 and the FSM goes to IDLE. This also covers PWM stuck high.
  - SPEED holds its last value.

## Timing
- Reset values: SPEED=0, vld=0, err=0, lost=1, FSM=IDLE, all counters 0.
- PWM sampled low at clock edge k sets pwm_s=0 at edge k. At edge k+1, SPEED, err and vld=1 are registered. vld is high for exactly one cycle.
- Rise and fall latency are equal, so the measured width equals the input width.
- Back-to-back pulses need at least one low cycle. A new rise on the cycle after a publish is measured normally.
- rst mid-pulse: the next edge forces reset values. No vld is issued for the truncated pulse.

## Configuration
- **ESC_DEC_GLITCH_FILT_EN defined:** pwm_s changes only after PWM holds the new level for 3 consecutive samples.
  - Both edges are delayed by 2 more cycles, so width is preserved.
  - Pulses or dropouts shorter than 3 cycles are ignored.
- **Not defined:** pwm_s is the single registered copy of PWM, and every 1-cycle level change counts.

## Structure
- Package esc_pkg holds:
  - the SPEED width constant (11);
  - default OFFSET/SCALE, shared with the ESC interface;
  - the FSM state enum (IDLE, LOW, HIGH).
- One sub-module, esc_glitch_filter (3-sample level qualifier), is instantiated only under ESC_DEC_GLITCH_FILT_EN.

## Test plan
- **Nominal widths:** high widths of 6280, then 6460, then 6250 clocks, each followed by 1000 low.
  - Required: vld pulses with SPEED=10, 70, 0, all err=0, lost=0 after the first publish.
- **Range edges:**
  - W=6249 → SPEED=0, err=1.
  - W=12391 → SPEED=2047, err=0.
  - W=12394 → SPEED=2047, err=1.
  - W=6252 → SPEED=0; W=6253 → SPEED=1.
- **Latency:** fall at edge k → vld high after edge k+1 and low after edge k+2 (filter off).
- **Reset mid-pulse:** rst asserted 3000 cycles into a high, PWM still high, then a full 6280-clock pulse.
  - Required: no vld for the cut pulse; the next pulse gives SPEED=10.
- **Loss:**
  - PWM held low for TO_CYC clocks → lost=1, SPEED unchanged.
  - PWM held high for TO_CYC clocks → lost=1, no vld until a low followed by a complete pulse.
- **Glitch:** 6280-clock pulse with a 1-cycle low at clock 3000.
  - Filter on: one vld, SPEED=10.
  - Filter off: first vld with err=1, second pulse of 3279 clocks also err=1, SPEED=0.
